decoder_scan_sequencer: RTL and testbench
=========================================

DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 4: width of the dwell input and the internal dwell counter.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  scan request, sampled each clk edge.
REQ-005 stop  input  1  abort request, sampled each clk edge.
REQ-006 cont  input  1  continuous-scan select, captured at accepted start.
REQ-007 dwell  input  DWELL_W  enable-high length minus one per select, captured at accepted start.
REQ-008 A  output  1  decoder select MSB.
REQ-009 B  output  1  decoder select middle bit.
REQ-010 C  output  1  decoder select LSB.
REQ-011 en  output  1  decoder enable.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 done  output  1  one-cycle pulse on normal completion of a single scan.

Function
REQ-014 All outputs SHALL be registered; select index is {A,B,C}, with A as MSB.
REQ-015 FSM states SHALL be IDLE, ON, GAP.
REQ-016 IDLE: en=0, {A,B,C}=000, busy=0; start=1 and stop=0 -> capture dwell and cont, go to ON with index 000.
REQ-017 Start accepted at edge n SHALL give en=1 and busy=1 in cycle n+1.
REQ-018 ON: en=1, index held, dwell counter increments from 0; counter equal to the captured dwell -> go to GAP and clear counter, so en stays high exactly dwell+1 cycles.
REQ-019 GAP: exactly one cycle with en=0 and index unchanged (break-before-make for the decoder).
REQ-020 GAP with index<7 -> index+1, go to ON.
REQ-021 GAP with index=7 and captured cont=1 -> index wraps to 000, go to ON.
REQ-022 GAP with index=7 and captured cont=0 -> go to IDLE with done=1 for that single cycle.
REQ-023 Each select SHALL occupy dwell+2 cycles; a single scan started at edge n SHALL assert done in cycle n+8*(dwell+2)+1.
REQ-024 stop=1 in ON or GAP -> next cycle IDLE with en=0, index 000, busy=0, and done=0.
REQ-025 start while busy SHALL be ignored; changes to dwell or cont while busy SHALL have no effect.
REQ-026 start and stop both high in IDLE -> stop wins and the FSM stays in IDLE.
REQ-027 dwell=0 is legal and SHALL give en high for 1 cycle per select.
REQ-028 Dwell counter SHALL be DWELL_W bits and SHALL never wrap, because it compares against the captured dwell value.
REQ-029 en SHALL never be high in the same cycle that the index changes.

Reset
REQ-030 rst=1 at a clk edge SHALL force IDLE, en=0, {A,B,C}=000, busy=0, done=0, and clear the counter, regardless of state.
REQ-031 rst SHALL take priority over start and stop.
REQ-032 An assertion of rst mid-scan SHALL abort the scan without a done pulse.
REQ-033 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 rst then start pulse at edge 0, dwell=2, cont=0 -> ABC steps 000..111, en high 3 cycles then low 1 cycle per select, done=1 in cycle 33 only, then IDLE.
REQ-035 dwell=0, cont=1, start -> en toggles 1,0 per select, ABC wraps 111->000, no done; stop after 20 cycles -> next cycle en=0, ABC=000, busy=0.
REQ-036 Start at edge n, second start at n+5, dwell=3 -> the second start is ignored, and done occurs only at n+41.
REQ-037 start and stop high together in IDLE -> busy stays 0 and en stays 0.
REQ-038 rst pulsed while ABC=101 and en=1 -> next cycle all outputs are 0; start at the following edge begins a fresh scan at ABC=000.
REQ-039 Bench SHALL connect the outputs to the existing 3-to-8 decoder and check that at most one Y is active per cycle, and that no Y is active in GAP or IDLE cycles.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Purpose: steps a 3-to-8 decoder through all eight selects {A,B,C} = 000..111.
// Each select has the enable high for dwell+1 cycles, followed by one gap cycle
// with the enable low, so the decoder always breaks before it makes.
// A single scan ends with a one-cycle done pulse. Continuous mode wraps
// 111 -> 000 until stop is asserted.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   start      scan request; accepted only in IDLE when stop is low
//   stop       abort request; returns to IDLE on the next edge
//   cont       continuous-scan select, captured when start is accepted
//   dwell      enable-high length minus one, captured when start is accepted
//   A, B, C    decoder select (A is the MSB), registered
//   en         decoder enable, registered
//   busy       high while a scan is in progress, registered
//   done       one-cycle pulse when a single scan completes, registered
//   state_dbg  current FSM state (0 = IDLE, 1 = ON, 2 = GAP)
//
// Handshake: start and stop are level samples taken at each rising edge.
// There is no ready. A start that is seen while busy is dropped.
// stop wins over start in the same cycle.
// -----------------------------------------------------------------------------
module decoder_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           index_q, index_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_cap_q, dwell_cap_d;
  logic                 cont_cap_q, cont_cap_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      index_q     <= 3'd0;
      cnt_q       <= '0;
      dwell_cap_q <= '0;
      cont_cap_q  <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      dwell_cap_q <= dwell_cap_d;
      cont_cap_q  <= cont_cap_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    dwell_cap_d = dwell_cap_q;
    cont_cap_d  = cont_cap_q;
    case (state_q)
      S_IDLE: begin
        index_d = 3'd0;
        cnt_d   = '0;
        if (start && !stop) begin
          state_d     = S_ON;
          dwell_cap_d = dwell;
          cont_cap_d  = cont;
        end
      end
      S_ON: begin
        if (stop) begin
          state_d = S_IDLE;
          index_d = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_cap_q) begin
          // The counter stops at the captured dwell, so it never wraps.
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = '0;
        if (stop) begin
          state_d = S_IDLE;
          index_d = 3'd0;
        end else if (index_q != 3'd7) begin
          state_d = S_ON;
          index_d = index_q + 3'd1;
        end else if (cont_cap_q) begin
          state_d = S_ON;
          index_d = 3'd0;
        end else begin
          state_d = S_IDLE;
          index_d = 3'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        index_d = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // The outputs are computed from the next state and registered. This way
  // en and the select change on the same edge, and en only rises on entry to ON.
  always_comb begin
    en_d   = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_GAP) && !stop && (index_q == 3'd7) && !cont_cap_q;
  end

  assign A         = index_q[2];
  assign B         = index_q[1];
  assign C         = index_q[0];
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//
// Directed bench for decoder_scan_sequencer. The bench models a 3-to-8 decoder
// on the DUT outputs. Expected per-cycle values come from the scan timing:
// cycle k after the accepting edge is part of select ((k-1)/(d+2)) mod 8, and
// en is high when (k-1) mod (d+2) <= d.
// -----------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [3:0] dwell;
  logic       A, B, C, en, busy, done;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  decoder_scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .dwell(dwell), .A(A), .B(B), .C(C), .en(en), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Checking
  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] decode(input logic e, input logic [2:0] sel);
    decode = e ? (8'd1 << sel) : 8'd0;
  endfunction

  // Checks every DUT output, the decoder lines and the state.
  // exp_sel is only meaningful while busy.
  task automatic check_cycle(input string tag, input bit exp_en, input int exp_sel,
                             input bit exp_busy, input bit exp_done);
    logic [2:0] esel;
    logic [1:0] est;
    esel = exp_busy ? 3'(exp_sel) : 3'd0;
    est  = !exp_busy ? 2'd0 : (exp_en ? 2'd1 : 2'd2);
    check_val({tag, ".en"},   8'(en),        8'(exp_en));
    check_val({tag, ".abc"},  8'({A, B, C}), 8'(esel));
    check_val({tag, ".busy"}, 8'(busy),      8'(exp_busy));
    check_val({tag, ".done"}, 8'(done),      8'(exp_done));
    check_val({tag, ".y"},    decode(en, {A, B, C}), decode(exp_en, esel));
    check_val({tag, ".st"},   8'(state_dbg), 8'(est));
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic c, input logic [3:0] d);
    start = s;
    stop  = p;
    cont  = c;
    dwell = d;
  endtask

  function automatic int scan_sel(input int k, input int d);
    scan_sel = ((k - 1) / (d + 2)) % 8;
  endfunction

  function automatic bit scan_en(input int k, input int d);
    scan_en = ((k - 1) % (d + 2)) <= d;
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 4'd0);
    step();
    step();
    check_cycle("reset", 0, 0, 0, 0);

    // Test 1: single scan with dwell=2. The start edge is the first after reset.
    rst = 1'b0;
    drive(1, 0, 0, 4'd2);
    step();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      check_cycle($sformatf("single.k%0d", k), scan_en(k, 2), scan_sel(k, 2), 1, 0);
      step();
    end
    check_cycle("single.done33", 0, 0, 0, 1);
    step();
    check_cycle("single.idle34", 0, 0, 0, 0);

    // Test 2: continuous scan with dwell=0, then stop after 20 cycles.
    drive(1, 0, 1, 4'd0);
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check_cycle($sformatf("cont.k%0d", k), scan_en(k, 0), scan_sel(k, 0), 1, 0);
      if (k == 20) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    check_cycle("cont.stop", 0, 0, 0, 0);
    step();

    // Test 3: dwell=3. A second start at n+5 with changed dwell and cont
    // must be ignored.
    drive(1, 0, 0, 4'd3);
    step();
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      if (c <= 40)
        check_cycle($sformatf("ign.c%0d", c), scan_en(c, 3), scan_sel(c, 3), 1, 0);
      else
        check_cycle($sformatf("ign.c%0d", c), 0, 0, 0, c == 41);
      if (c == 5) drive(1, 0, 1, 4'd0);
      step();
      if (c == 5) start = 1'b0;
    end
    drive(0, 0, 0, 4'd0);

    // Test 4: start and stop together in IDLE, so stop wins.
    drive(1, 1, 0, 4'd2);
    step();
    check_cycle("startstop.1", 0, 0, 0, 0);
    step();
    check_cycle("startstop.2", 0, 0, 0, 0);
    drive(0, 0, 0, 4'd0);
    step();

    // Test 5: reset while ABC=101 and en=1, then a fresh scan.
    drive(1, 0, 0, 4'd1);
    step();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check_cycle($sformatf("rst.k%0d", k), scan_en(k, 1), scan_sel(k, 1), 1, 0);
      if (k < 16) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cycle("rst.after", 0, 0, 0, 0);
    drive(1, 0, 0, 4'd1);
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_cycle($sformatf("rst.fresh%0d", k), scan_en(k, 1), scan_sel(k, 1), 1, 0);
      if (k == 4) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    check_cycle("rst.stop", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
